tt_sweeper: RTL and testbench
=============================

TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_IN, 4, stimulus width (DUT input count), 1..8
- N_OUT, 2, response width (DUT output count), 1..8
- HOLD, 10, cycles each vector is held, >=1
- EXPECTED, all zeros, packed golden table of (2**N_IN)*N_OUT bits; vector v expects EXPECTED[v*N_OUT +: N_OUT]

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a sweep when not busy
- abort  in  1  pulse; cancels a running sweep
- stim_o  out  N_IN  vector to DUT; MSB is first DUT input (a), LSB last (d)
- resp_i  in  N_OUT  DUT response; MSB is first output (y)
- busy  out  1  sweep in progress
- done  out  1  last sweep completed without abort; level until next start/reset
- pass  out  1  done and zero mismatches
- err_count  out  N_IN+1  mismatching vectors in last sweep
- first_err_vec  out  N_IN  index of lowest mismatching vector
- first_err_valid  out  1  first_err_vec is meaningful

Function
REQ-003 FSM states SHALL be IDLE, DRIVE, FINISH; FINISH is a one-cycle state that sets done, then returns to IDLE.
REQ-004 IDLE + start=1 at edge t SHALL give, from t+1: busy=1, stim_o=0, done=0, pass=0, err_count=0, first_err_valid=0.
REQ-005 Vector index SHALL ascend 0,1,...,2**N_IN-1, each held on stim_o exactly HOLD cycles, no gaps.
REQ-006 resp_i SHALL be sampled on the final cycle of each vector's hold (HOLD=1: the only cycle) and compared to that vector's EXPECTED slice.
REQ-007 Each mismatch SHALL increment err_count by 1; err_count cannot overflow (max 2**N_IN fits N_IN+1 bits).
REQ-008 First mismatch of a sweep SHALL load first_err_vec and set first_err_valid; later mismatches SHALL not change them.
REQ-009 Sweep SHALL occupy exactly (2**N_IN)*HOLD busy cycles; the cycle after the last sample, FINISH drives busy=0, done=1, pass=(err_count==0 including last sample), stim_o=0.
REQ-010 start while busy SHALL be ignored.
REQ-011 start in FINISH or IDLE-after-done SHALL start a fresh sweep per REQ-004.
REQ-012 abort while busy SHALL, next cycle, return to IDLE with busy=0, done=0, pass=0, stim_o=0; err_count/first_err_* hold partial values.
REQ-013 start and abort asserted together SHALL: abort wins if busy, start wins if idle.
REQ-014 abort while idle SHALL have no effect.
REQ-015 Final vector 2**N_IN-1 SHALL not wrap to 0 within a sweep.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, stim_o=0, err_count=0, first_err_vec=0, first_err_valid=0, hold counter=0.
REQ-017 Reset mid-sweep SHALL discard all progress; no sweep resumes after release without a new start.

Structure
REQ-018 Package tt_pkg SHALL hold the state enum (IDLE, DRIVE, FINISH) and default N_IN, N_OUT, HOLD constants.
REQ-019 One sub-module tt_hold_timer SHALL count 0..HOLD-1 and emit a last-cycle strobe used for sampling and vector advance.
REQ-020 Implementation SHALL be synchronous to clk except the rst_n clear; no latches.

Verification
REQ-021 Bench SHALL cover, with N_IN=4, N_OUT=2, HOLD=10 unless stated:
- Golden DUT matching EXPECTED, start -> stim_o 0..15 each 10 cycles, busy 160 cycles, done=1, pass=1, err_count=0.
- DUT wrong only at vectors 5 and 12 -> err_count=2, first_err_vec=5, first_err_valid=1, pass=0.
- abort at cycle 47 of sweep -> busy=0 next cycle, done=0, stim_o=0, err_count holds partial value.
- rst_n low at cycle 80 -> all outputs zero same cycle; no activity after release until start.
- HOLD=1, N_IN=2 -> stim_o 0,1,2,3 on consecutive cycles, done on cycle 5 after start; start during busy ignored.
- start in FINISH cycle -> new sweep begins, err_count and first_err_valid cleared.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: controller states and default geometry.
package tt_pkg;

    localparam int TT_N_IN  = 4;
    localparam int TT_N_OUT = 2;
    localparam int TT_HOLD  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } tt_state_e;

endpackage

// File: rtl/tt_hold_timer.sv
// Per-vector hold timer: counts 0..HOLD-1 while enabled and strobes on the final hold cycle.
module tt_hold_timer #(
    parameter int HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

    logic [CW-1:0] r_cnt;

    // Hold counter; wraps to zero on the last cycle so the next vector starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en) begin
            if (r_cnt == LAST_CNT) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_last = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector in turn, compares the DUT
// response against a packed golden table and reports error count and first failing vector.
module tt_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN  = TT_N_IN,
    parameter int N_OUT = TT_N_OUT,
    parameter int HOLD  = TT_HOLD,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   stim_o,
    input  logic [N_OUT-1:0]  resp_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int EW = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    tt_state_e        r_state, w_state_nxt;
    logic [N_IN-1:0]  r_vec, w_vec_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic [EW-1:0]    r_err_count, w_err_nxt, w_err_after;
    logic [N_IN-1:0]  r_first_err_vec, w_fev_nxt;
    logic             r_first_err_valid, w_fevalid_nxt;
    logic             w_last, w_clr, w_en, w_go, w_mismatch;
    logic [N_OUT-1:0] w_exp;

    assign w_en  = (r_state == DRIVE);
    assign w_clr = (r_state != DRIVE) || abort;

    tt_hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_last (w_last)
    );

    assign w_exp       = EXPECTED[32'(r_vec) * N_OUT +: N_OUT];
    assign w_mismatch  = (resp_i != w_exp);
    assign w_err_after = w_mismatch ? (r_err_count + EW'(1)) : r_err_count;
    // A running sweep ignores start; abort takes priority there.
    assign w_go        = start && (r_state != DRIVE);

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_err_nxt     = r_err_count;
        w_fev_nxt     = r_first_err_vec;
        w_fevalid_nxt = r_first_err_valid;
        if (w_go) begin
            w_state_nxt   = DRIVE;
            w_vec_nxt     = {N_IN{1'b0}};
            w_busy_nxt    = 1'b1;
            w_done_nxt    = 1'b0;
            w_pass_nxt    = 1'b0;
            w_err_nxt     = {EW{1'b0}};
            w_fev_nxt     = {N_IN{1'b0}};
            w_fevalid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                DRIVE: begin
                    if (abort) begin
                        w_state_nxt = IDLE;
                        w_vec_nxt   = {N_IN{1'b0}};
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b0;
                        w_pass_nxt  = 1'b0;
                    end else if (w_last) begin
                        w_err_nxt = w_err_after;
                        if (w_mismatch && !r_first_err_valid) begin
                            w_fev_nxt     = r_vec;
                            w_fevalid_nxt = 1'b1;
                        end else begin
                            w_fev_nxt     = r_first_err_vec;
                        end
                        if (r_vec == LAST_VEC) begin
                            w_state_nxt = FINISH;
                            w_vec_nxt   = {N_IN{1'b0}};
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = (w_err_after == {EW{1'b0}});
                        end else begin
                            w_vec_nxt   = r_vec + N_IN'(1);
                        end
                    end else begin
                        w_state_nxt = DRIVE;
                    end
                end
                FINISH: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_vec_nxt     = {N_IN{1'b0}};
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b0;
                    w_pass_nxt    = 1'b0;
                    w_err_nxt     = {EW{1'b0}};
                    w_fev_nxt     = {N_IN{1'b0}};
                    w_fevalid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_vec             <= {N_IN{1'b0}};
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= {EW{1'b0}};
            r_first_err_vec   <= {N_IN{1'b0}};
            r_first_err_valid <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_vec             <= w_vec_nxt;
            r_busy            <= w_busy_nxt;
            r_done            <= w_done_nxt;
            r_pass            <= w_pass_nxt;
            r_err_count       <= w_err_nxt;
            r_first_err_vec   <= w_fev_nxt;
            r_first_err_valid <= w_fevalid_nxt;
        end
    end

    assign stim_o          = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_vec   = r_first_err_vec;
    assign first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: a 4-in/2-out, HOLD=10 instance and a 2-in/1-out, HOLD=1 instance.
module tb_tt_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort;
    logic [1:0] resp;
    logic [3:0] stim;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] fev;
    logic       fevalid;

    logic       start2, abort2;
    logic [1:0] stim2;
    logic [0:0] resp2;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    logic [1:0] fev2;
    logic       fevalid2;

    int checks = 0;
    int errors = 0;

    // golden(v) = v[1:0] ^ v[3:2], tabulated by hand
    tt_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(10), .EXPECTED(32'h1B4EB1E4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim_o(stim), .resp_i(resp),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(fev), .first_err_valid(fevalid)
    );

    // parity of the 2-bit vector: 0,1,1,0
    tt_sweeper #(.N_IN(2), .N_OUT(1), .HOLD(1), .EXPECTED(4'b0110)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .stim_o(stim2), .resp_i(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_vec(fev2), .first_err_valid(fevalid2)
    );

    assign resp2 = ^stim2;

    function automatic logic [1:0] gold(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b[1:0] ^ b[3:2];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp = 2'b00;
        start2 = 1'b0; abort2 = 1'b0;
        #2;
        checks++;
        if ({busy, done, pass, fevalid, stim, err_count, fev} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, fevalid, stim, err_count, fev});
        end
        checks++;
        if ({busy2, done2, pass2, fevalid2, stim2, err2, fev2} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs2: got %h want 0", {busy2, done2, pass2, fevalid2, stim2, err2, fev2});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_golden();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 160; i++) begin
            resp = gold(i / 10);
            checks++;
            if ({busy, done, pass, stim} !== {3'b100, 4'(i / 10)}) begin
                errors++;
                $display("FAIL golden_drive[%0d]: got busy/done/pass/stim %b want %b", i,
                         {busy, done, pass, stim}, {3'b100, 4'(i / 10)});
            end
            step();
        end
        checks++;
        if ({busy, done, pass, stim, err_count, fevalid} !== {3'b011, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL golden_finish: got %b want %b", {busy, done, pass, stim, err_count, fevalid},
                     {3'b011, 4'd0, 5'd0, 1'b0});
        end
        step();
        checks++;
        if ({busy, done, pass} !== 3'b011) begin
            errors++;
            $display("FAIL golden_done_level: got %b want 011", {busy, done, pass});
        end
    endtask

    task automatic test_errors();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 160; i++) begin
            resp = gold(i / 10) ^ (((i / 10) == 5 || (i / 10) == 12) ? 2'b10 : 2'b00);
            if (i == 60) begin
                checks++;
                if ({err_count, fev, fevalid} !== {5'd1, 4'd5, 1'b1}) begin
                    errors++;
                    $display("FAIL errors_mid: got err/fev/valid %b want %b", {err_count, fev, fevalid},
                             {5'd1, 4'd5, 1'b1});
                end
            end
            step();
        end
        checks++;
        if ({busy, done, pass, err_count, fev, fevalid} !== {3'b010, 5'd2, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL errors_finish: got %b want %b", {busy, done, pass, err_count, fev, fevalid},
                     {3'b010, 5'd2, 4'd5, 1'b1});
        end
    endtask

    // Called while the previous sweep sits in its FINISH cycle.
    task automatic test_finish_restart();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, done, pass, stim, err_count, fevalid} !== {3'b100, 4'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL restart_clear: got %b want %b", {busy, done, pass, stim, err_count, fevalid},
                     {3'b100, 4'd0, 5'd0, 1'b0});
        end
        for (int i = 0; i < 160; i++) begin
            resp = ((i % 10) == 9) ? gold(i / 10) : ~gold(i / 10);
            checks++;
            if ({busy, stim} !== {1'b1, 4'(i / 10)}) begin
                errors++;
                $display("FAIL restart_drive[%0d]: got %b want %b", i, {busy, stim}, {1'b1, 4'(i / 10)});
            end
            step();
        end
        checks++;
        if ({busy, done, pass, err_count, fevalid} !== {3'b011, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL sample_point: got %b want %b", {busy, done, pass, err_count, fevalid},
                     {3'b011, 5'd0, 1'b0});
        end
        step();
    endtask

    task automatic test_abort();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 47; i++) begin
            resp = gold(i / 10) ^ (((i / 10) == 1 || (i / 10) == 3) ? 2'b01 : 2'b00);
            step();
        end
        checks++;
        if ({busy, stim} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL abort_pre: got %b want %b", {busy, stim}, {1'b1, 4'd4});
        end
        resp = 2'b11;
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, pass, stim, err_count, fev, fevalid} !== {3'b000, 4'd0, 5'd2, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL abort_result: got %b want %b", {busy, done, pass, stim, err_count, fev, fevalid},
                     {3'b000, 4'd0, 5'd2, 4'd1, 1'b1});
        end
        step();
        checks++;
        if ({busy, stim, err_count} !== {1'b0, 4'd0, 5'd2}) begin
            errors++;
            $display("FAIL abort_stays_idle: got %b want %b", {busy, stim, err_count}, {1'b0, 4'd0, 5'd2});
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        checks++;
        if ({busy, done, pass, stim, err_count, fev, fevalid} !== {3'b000, 4'd0, 5'd2, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL abort_idle_noop: got %b want %b", {busy, done, pass, stim, err_count, fev, fevalid},
                     {3'b000, 4'd0, 5'd2, 4'd1, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            resp = gold(i / 10) ^ (((i / 10) == 2) ? 2'b11 : 2'b00);
            step();
        end
        checks++;
        if ({busy, stim, err_count, fevalid} !== {1'b1, 4'd8, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b want %b", {busy, stim, err_count, fevalid}, {1'b1, 4'd8, 5'd1, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, fevalid, stim, err_count, fev} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %h want 0", {busy, done, pass, fevalid, stim, err_count, fev});
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({busy, done, stim, err_count} !== 11'd0) begin
                errors++;
                $display("FAIL reset_mid_quiet[%0d]: got %b want 0", i, {busy, done, stim, err_count});
            end
        end
    endtask

    task automatic test_small();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy2, done2, stim2} !== {2'b10, 2'(k)}) begin
                errors++;
                $display("FAIL small_drive[%0d]: got %b want %b", k, {busy2, done2, stim2}, {2'b10, 2'(k)});
            end
            start2 = (k == 0) ? 1'b1 : 1'b0;
            step();
        end
        start2 = 1'b0;
        checks++;
        if ({busy2, done2, pass2, err2, stim2} !== {3'b011, 3'd0, 2'd0}) begin
            errors++;
            $display("FAIL small_finish: got %b want %b", {busy2, done2, pass2, err2, stim2}, {3'b011, 3'd0, 2'd0});
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_errors();
        test_finish_restart();
        test_abort();
        test_reset_mid();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
